// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with a 2-entry instruction buffer and credit-based bus requests
//
// Ports:
//    clk, rst_n      clock and asynchronous active-low reset
//    ibus_req_o      read request valid, issued while credits remain
//    ibus_addr_o     request word address (the fetch PC)
//    ibus_gnt_i      request accepted when ibus_req_o & ibus_gnt_i
//    ibus_rvalid_i   in-order read response valid
//    ibus_rdata_i    instruction word of the response
//    jump_en_i       redirect from execute
//    jump_addr_i     redirect target (low two bits ignored)
//    hold_i          decode stall; the presented instruction is kept
//    inst_valid_o    inst_o / inst_addr_o carry a fetched instruction
//    inst_o          instruction to decode (NOP when not valid)
//    inst_addr_o     address of inst_o (0 when not valid)
module ifetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t      state, state_nx;
   logic        live;
   logic [31:0] pc, pc_nx, rsp_pc, rsp_pc_nx, target;
   logic [1:0]  outst, outst_nx, disc, disc_nx, cnt, cnt_nx, cnt_pop;
   logic [31:0] a0, a1, d0, d1, a0_nx, a1_nx, d0_nx, d1_nx;
   logic        accept, push, pop, drop;
   // rsp_pc is the address of the next non-stale response: after a redirect all
   // stale responses are dropped, so the surviving ones are consecutive words
   // starting at the redirect target.
   always_comb begin
      target       = {jump_addr_i[31:2], 2'b00};
      ibus_req_o   = live && state == RUN && ({1'b0, outst} + {1'b0, cnt} < 3'd2);
      ibus_addr_o  = pc;
      inst_valid_o = cnt != 2'd0;
      inst_o       = inst_valid_o ? d0 : 32'h0000_0001;
      inst_addr_o  = inst_valid_o ? a0 : 32'h0;
      accept       = ibus_req_o & ibus_gnt_i;
      pop          = inst_valid_o & ~hold_i;
      drop         = ibus_rvalid_i & (disc != 2'd0);
      push         = ibus_rvalid_i & (disc == 2'd0) & ~jump_en_i;
      outst_nx     = outst + {1'b0, accept} - {1'b0, ibus_rvalid_i};
      disc_nx      = jump_en_i ? outst_nx : disc - {1'b0, drop};
      pc_nx        = jump_en_i ? target : accept ? pc + 32'd4 : pc;
      rsp_pc_nx    = jump_en_i ? target : push ? rsp_pc + 32'd4 : rsp_pc;
      // pop shifts the tail forward first, then a push lands in the first free slot
      cnt_pop      = cnt - {1'b0, pop};
      a0_nx        = (push && cnt_pop == 2'd0) ? rsp_pc : pop ? a1 : a0;
      d0_nx        = (push && cnt_pop == 2'd0) ? ibus_rdata_i : pop ? d1 : d0;
      a1_nx        = (push && cnt_pop == 2'd1) ? rsp_pc : a1;
      d1_nx        = (push && cnt_pop == 2'd1) ? ibus_rdata_i : d1;
      cnt_nx       = jump_en_i ? 2'd0 : cnt_pop + {1'b0, push};
      // FLUSH exactly while stale responses remain to be dropped
      state_nx     = disc_nx != 2'd0 ? FLUSH : RUN;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         live   <= 1'b0;
         pc     <= RESET_ADDR;
         rsp_pc <= RESET_ADDR;
         outst  <= 2'd0;
         disc   <= 2'd0;
         cnt    <= 2'd0;
         a0     <= 32'h0;
         a1     <= 32'h0;
         d0     <= 32'h0;
         d1     <= 32'h0;
      end else begin
         state  <= state_nx;
         live   <= 1'b1;
         pc     <= pc_nx;
         rsp_pc <= rsp_pc_nx;
         outst  <= outst_nx;
         disc   <= disc_nx;
         cnt    <= cnt_nx;
         a0     <= a0_nx;
         a1     <= a1_nx;
         d0     <= d0_nx;
         d1     <= d1_nx;
      end
   end
endmodule
